// File: rtl/crc16_sched.sv
// crc16_sched: arbitrates two requesters onto one serial crc16 engine, feeds
// the latched 64-bit payload MSB first, collects the 16-bit remainder and
// returns it over a valid/ack handshake before releasing the engine.
// Optional macro CRC16_SCHED_RR_EN: round-robin arbitration instead of the
// default fixed priority (requester 0 wins).
`timescale 1ns/1ps
module crc16_sched #(
   parameter int NREQ  = 2,
   parameter int DBITS = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [DBITS-1:0] req_data0,
   input  logic [DBITS-1:0] req_data1,
   output logic [NREQ-1:0]  gnt,
   output logic [15:0]      res,
   output logic             res_valid,
   input  logic             res_ack,
   output logic             busy,
   output logic             crc16_start,
   output logic             crc16_s_in,
   output logic             crc16_rec,
   input  logic             crc16_out,
   input  logic             crc16_ready,
   input  logic             crc16_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_FEED, S_COLLECT, S_RESULT, S_RELEASE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DBITS-1:0] r_shift;
   logic [5:0]       r_feed_cnt;
   logic [4:0]       r_cap_cnt;
   logic             w_any_req;
   logic             w_win;
   logic [NREQ-1:0]  w_gnt_sel;
   logic             w_cap_inc;

   assign w_any_req = |req;
   assign w_gnt_sel = w_win ? NREQ'(2) : NREQ'(1);
   // Capture count saturates at 16; later ready bits are dropped.
   assign w_cap_inc = crc16_ready && (r_cap_cnt < 5'd16);

`ifdef CRC16_SCHED_RR_EN
   logic r_last;

   // On a tie the requester that did not win last time is granted.
   assign w_win = (&req) ? ~r_last : ~req[0];

   // Last-winner register; preset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_last <= 1'b1;
      else if (r_state == S_IDLE && w_any_req)
         r_last <= w_win;
   end
`else
   // Fixed priority: requester 0 always wins.
   assign w_win = ~req[0];
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_any_req) w_state_nxt = S_START;
         S_START:   w_state_nxt = S_FEED;
         S_FEED:    if (r_feed_cnt == 6'd63) w_state_nxt = S_COLLECT;
         S_COLLECT: if (crc16_done) w_state_nxt = S_RESULT;
         S_RESULT:  if (res_ack) w_state_nxt = S_RELEASE;
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Payload shift register: loaded on grant, shifted MSB-out while feeding.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && w_any_req)
         r_shift <= w_win ? req_data1 : req_data0;
      else if (r_state == S_START || r_state == S_FEED)
         r_shift <= {r_shift[DBITS-2:0], 1'b0};
   end

   // Registered outputs and counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt         <= '0;
         res         <= 16'h0000;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         crc16_start <= 1'b0;
         crc16_s_in  <= 1'b0;
         crc16_rec   <= 1'b0;
         r_feed_cnt  <= 6'd0;
         r_cap_cnt   <= 5'd0;
      end else begin
         crc16_start <= (w_state_nxt == S_START);
         crc16_rec   <= (w_state_nxt == S_RELEASE);
         busy        <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  gnt       <= w_gnt_sel;
                  res       <= 16'h0000;
                  r_cap_cnt <= 5'd0;
               end
            end
            S_START: begin
               r_feed_cnt <= 6'd0;
               crc16_s_in <= r_shift[DBITS-1];
            end
            S_FEED: begin
               r_feed_cnt <= r_feed_cnt + 6'd1;
               crc16_s_in <= (r_feed_cnt == 6'd63) ? 1'b0 : r_shift[DBITS-1];
            end
            S_COLLECT: begin
               if (w_cap_inc) begin
                  res       <= {res[14:0], crc16_out};
                  r_cap_cnt <= r_cap_cnt + 5'd1;
               end
               // A short engine still gets its partial result presented so the
               // requester can acknowledge and the engine can be released.
               if (crc16_done)
                  res_valid <= 1'b1;
            end
            S_RESULT: begin
               if (res_ack)
                  res_valid <= 1'b0;
            end
            S_RELEASE: begin
               gnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc16_sched.sv
// tb_crc16_sched: directed bench for crc16_sched with a behavioural crc16
// engine (poly 0x8005, preset 16'hFFFF, complemented remainder out MSB first).
`timescale 1ns/1ps
module tb_crc16_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [63:0] req_data0, req_data1;
   logic [1:0]  gnt;
   logic [15:0] res;
   logic        res_valid, res_ack, busy;
   logic        crc16_start, crc16_s_in, crc16_rec;
   logic        crc16_out, crc16_ready, crc16_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   crc16_sched #(.NREQ(2), .DBITS(64)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .req_data0(req_data0), .req_data1(req_data1),
      .gnt(gnt), .res(res), .res_valid(res_valid), .res_ack(res_ack),
      .busy(busy), .crc16_start(crc16_start), .crc16_s_in(crc16_s_in),
      .crc16_rec(crc16_rec), .crc16_out(crc16_out),
      .crc16_ready(crc16_ready), .crc16_done(crc16_done)
   );

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   function automatic logic [15:0] crc16_calc(input logic [63:0] d);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 63; i >= 0; i--) c = crc_step(c, d[i]);
      return ~c;
   endfunction

   // Behavioural engine, driven on the falling edge.
   typedef enum logic [1:0] {E_IDLE, E_ABS, E_OUT, E_DONE} e_t;
   e_t          e_st;
   logic [15:0] e_crc, e_sh;
   int          e_n, e_k;
   int          e_lim = 16;

   always @(negedge clk) begin
      if (!rst_n) begin
         e_st        <= E_IDLE;
         crc16_ready <= 1'b0;
         crc16_out   <= 1'b0;
         crc16_done  <= 1'b0;
      end else begin
         case (e_st)
            E_IDLE: if (crc16_start) begin
               e_crc <= 16'hFFFF;
               e_n   <= 0;
               e_st  <= E_ABS;
            end
            E_ABS: begin
               e_crc <= crc_step(e_crc, crc16_s_in);
               e_n   <= e_n + 1;
               if (e_n == 63) begin
                  e_sh <= ~crc_step(e_crc, crc16_s_in);
                  e_k  <= 0;
                  e_st <= E_OUT;
               end
            end
            E_OUT: begin
               if (e_k < e_lim) begin
                  crc16_ready <= 1'b1;
                  crc16_out   <= e_sh[15];
                  e_sh        <= {e_sh[14:0], 1'b0};
                  e_k         <= e_k + 1;
               end else begin
                  crc16_ready <= 1'b0;
                  crc16_out   <= 1'b0;
                  crc16_done  <= 1'b1;
                  e_st        <= E_DONE;
               end
            end
            E_DONE: if (crc16_rec) begin
               crc16_done <= 1'b0;
               e_st       <= E_IDLE;
            end
            default: e_st <= E_IDLE;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction starting from an IDLE cycle.
   task automatic txn(input string tag, input logic [1:0] rq, input logic [1:0] exp_g,
                      input logic [63:0] exp_d, input int ack_dly, input bit disturb,
                      input int nbits, input bit keep);
      logic [63:0] ser;
      logic [15:0] exp_r, hold_r;
      int          lat;
      bit          ok;
      ser = '0;
      req = rq;
      step();
      chk({tag, "_grant"}, {60'd0, gnt, crc16_start, busy}, {60'd0, exp_g, 2'b11});
      if (!keep) req = 2'b00;
      for (int i = 0; i < 64; i++) begin
         step();
         ser = {ser[62:0], crc16_s_in};
         if (i == 0) chk({tag, "_start_pulse"}, {63'd0, crc16_start}, 64'd0);
         if (disturb && i == 10) begin
            req_data0 = ~req_data0;
            req       = 2'b00;
            res_ack   = 1'b1;
         end
         if (disturb && i == 11) res_ack = 1'b0;
      end
      chk({tag, "_serial"}, ser, exp_d);
      step();
      chk({tag, "_s_in_idle"}, {63'd0, crc16_s_in}, 64'd0);
      lat = 1;
      while (!res_valid && lat < 100) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(2 + nbits));
      exp_r = crc16_calc(exp_d) >> (16 - nbits);
      if (nbits < 16)
         $display("NOTE %s: engine protocol violation, done after %0d of 16 bits", tag, nbits);
      chk({tag, "_res"}, {48'd0, res}, {48'd0, exp_r});
      chk({tag, "_result_ctl"}, {60'd0, res_valid, crc16_rec, gnt}, {60'd0, 2'b10, exp_g});
      ok = 1'b1;
      hold_r = res;
      repeat (ack_dly) begin
         step();
         if (!(res_valid && !crc16_rec && res == hold_r && gnt == exp_g)) ok = 1'b0;
      end
      if (ack_dly > 0) chk({tag, "_hold_stable"}, {63'd0, ok}, 64'd1);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      chk({tag, "_rec"}, {59'd0, crc16_rec, res_valid, gnt, busy}, {59'd0, 2'b10, exp_g, 1'b1});
      step();
      chk({tag, "_release"}, {59'd0, crc16_rec, res_valid, gnt, busy}, 64'd0);
   endtask

`ifdef CRC16_SCHED_RR_EN
   localparam logic [1:0] G_MID = 2'b10;
`else
   localparam logic [1:0] G_MID = 2'b01;
`endif

   initial begin
      logic [63:0] d;
      rst_n = 1'b0; req = 2'b00; res_ack = 1'b0;
      req_data0 = '0; req_data1 = '0;
      repeat (3) step();
      chk("reset_out", {40'd0, gnt, res, res_valid, busy, crc16_start, crc16_s_in, crc16_rec},
          64'd0);
      rst_n = 1'b1;
      step();

      req_data0 = 64'h0000_0000_0000_0001;
      txn("single", 2'b01, 2'b01, req_data0, 0, 1'b0, 16, 1'b0);

      req_data1 = 64'hDEAD_BEEF_0123_4567;
      txn("delay_ack", 2'b10, 2'b10, req_data1, 20, 1'b0, 16, 1'b0);

      req_data0 = 64'hA5A5_5A5A_F00F_0FF0;
      req_data1 = 64'h0123_4567_89AB_CDEF;
      txn("simul0", 2'b11, 2'b01, req_data0, 0, 1'b0, 16, 1'b1);
      txn("simul1", 2'b11, G_MID, (G_MID == 2'b10) ? req_data1 : req_data0, 0, 1'b0, 16, 1'b1);
      txn("simul2", 2'b11, 2'b01, req_data0, 0, 1'b0, 16, 1'b1);
      req = 2'b00;

      req_data0 = 64'hFEDC_BA98_7654_3210;
      d = req_data0;
      txn("ignore", 2'b01, 2'b01, d, 0, 1'b1, 16, 1'b0);
      req_data0 = d;

      e_lim = 12;
      txn("short", 2'b10, 2'b10, req_data1, 0, 1'b0, 12, 1'b0);
      e_lim = 16;

      req = 2'b01;
      step();
      req = 2'b00;
      repeat (10) step();
      rst_n = 1'b0;
      step();
      step();
      chk("reset_mid_feed", {40'd0, gnt, res, res_valid, busy, crc16_start, crc16_s_in, crc16_rec},
          64'd0);
      rst_n = 1'b1;
      txn("post_reset", 2'b01, 2'b01, req_data0, 0, 1'b0, 16, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
